// File: rtl/mem_stage_cache_if.sv
// Backing-memory bus between the MEM-stage cache (master) and the memory (slave).
// One word moves per cycle in which mem_req and mem_ready are both high.
interface mem_stage_cache_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_wr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_cache.sv
// MEM-stage data cache: direct-mapped, 8 lines x 4 words, write-back/write-allocate,
// with a flush (dump) sequence that writes every dirty line back to memory.
module mem_stage_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUOut_tomem,
  input  logic [15:0] ReadData2_tomem,
  input  logic        DMemEn_tomem,
  input  logic        DMemWrite_tomem,
  input  logic        DMemDump_tomem,
  output logic [15:0] MemReadData,
  output logic        Stall,
  output logic        Err,
  output logic        DumpDone,
  mem_stage_cache_if.master mem
);

  typedef enum logic [2:0] {
    StIdle, StWriteback, StFill, StRespond, StFlush, StDumpDone
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [2:0]  line_q;
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [9:0]  tag_q  [8];
  logic [15:0] data_q [8][4];

  logic [9:0] addr_tag;
  logic [2:0] idx;
  logic [1:0] word;
  logic       hit;
  logic       idle_cmd;
  logic       access;
  logic       miss;
  logic       store_hit;
  logic       flush_dirty;
  logic       handshake;

  assign addr_tag  = ALUOut_tomem[15:6];
  assign idx       = ALUOut_tomem[5:3];
  assign word      = ALUOut_tomem[2:1];
  assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
  // A dump request in IDLE overrides any access presented in the same cycle.
  assign idle_cmd  = (state_q == StIdle) && !DMemDump_tomem;
  assign access    = (idle_cmd || (state_q == StRespond)) && DMemEn_tomem && !ALUOut_tomem[0];
  assign miss      = idle_cmd && DMemEn_tomem && !ALUOut_tomem[0] && !hit;
  assign store_hit = access && hit && DMemWrite_tomem;
  assign flush_dirty = (state_q == StFlush) && valid_q[line_q] && dirty_q[line_q];
  assign handshake = mem.mem_req && mem.mem_ready;

  always_comb begin
    Stall         = 1'b0;
    Err           = 1'b0;
    DumpDone      = 1'b0;
    MemReadData   = 16'h0000;
    mem.mem_req   = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = 16'h0000;
    mem.mem_wdata = 16'h0000;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          Stall = DMemDump_tomem || miss;
          Err   = !DMemDump_tomem && DMemEn_tomem && ALUOut_tomem[0];
        end
        StWriteback: begin
          Stall         = 1'b1;
          mem.mem_req   = 1'b1;
          mem.mem_wr    = 1'b1;
          mem.mem_addr  = {tag_q[idx], idx, cnt_q, 1'b0};
          mem.mem_wdata = data_q[idx][cnt_q];
        end
        StFill: begin
          Stall        = 1'b1;
          mem.mem_req  = 1'b1;
          mem.mem_addr = {addr_tag, idx, cnt_q, 1'b0};
        end
        StFlush: begin
          Stall = 1'b1;
          if (flush_dirty) begin
            mem.mem_req   = 1'b1;
            mem.mem_wr    = 1'b1;
            mem.mem_addr  = {tag_q[line_q], line_q, cnt_q, 1'b0};
            mem.mem_wdata = data_q[line_q][cnt_q];
          end
        end
        StDumpDone: DumpDone = 1'b1;
        default: ;
      endcase
      if (access && hit && !DMemWrite_tomem) begin
        MemReadData = data_q[idx][word];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      line_q  <= 3'd0;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (DMemDump_tomem) begin
            state_q <= StFlush;
            line_q  <= 3'd0;
            cnt_q   <= 2'd0;
          end else if (miss) begin
            state_q <= (valid_q[idx] && dirty_q[idx]) ? StWriteback : StFill;
          end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        StWriteback: begin
          if (handshake) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= StFill;
          end
        end
        StFill: begin
          if (handshake) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              valid_q[idx] <= 1'b1;
              dirty_q[idx] <= 1'b0;
              state_q      <= StRespond;
            end
          end
        end
        StRespond: begin
          if (store_hit) dirty_q[idx] <= 1'b1;
          state_q <= StIdle;
        end
        StFlush: begin
          if (flush_dirty) begin
            if (handshake) begin
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                dirty_q[line_q] <= 1'b0;
                line_q          <= line_q + 3'd1;
                if (line_q == 3'd7) state_q <= StDumpDone;
              end
            end
          end else begin
            line_q <= line_q + 3'd1;
            if (line_q == 3'd7) state_q <= StDumpDone;
          end
        end
        StDumpDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone decide what is a hit.
  always_ff @(posedge clk) begin
    if ((state_q == StFill) && handshake) begin
      data_q[idx][cnt_q] <= mem.mem_rdata;
      if (cnt_q == 2'd3) tag_q[idx] <= addr_tag;
    end
    if (store_hit) begin
      data_q[idx][word] <= ReadData2_tomem;
    end
  end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Randomized bench for mem_stage_cache: a transaction-level cache model predicts the memory
// traffic and load data of every access, plus directed scenarios with literal expectations.
module tb_mem_stage_cache;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ALUOut_tomem = 16'h0;
  logic [15:0] ReadData2_tomem = 16'h0;
  logic        DMemEn_tomem = 1'b0;
  logic        DMemWrite_tomem = 1'b0;
  logic        DMemDump_tomem = 1'b0;
  logic [15:0] MemReadData;
  logic        Stall;
  logic        Err;
  logic        DumpDone;

  mem_stage_cache_if bus ();

  mem_stage_cache dut (
    .clk             (clk),
    .rst             (rst),
    .ALUOut_tomem    (ALUOut_tomem),
    .ReadData2_tomem (ReadData2_tomem),
    .DMemEn_tomem    (DMemEn_tomem),
    .DMemWrite_tomem (DMemWrite_tomem),
    .DMemDump_tomem  (DMemDump_tomem),
    .MemReadData     (MemReadData),
    .Stall           (Stall),
    .Err             (Err),
    .DumpDone        (DumpDone),
    .mem             (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Backing memory (driven by the DUT) and the model's view of what memory must hold.
  logic [15:0] mem  [32768];
  logic [15:0] rmem [32768];
  txn_t log_q[$];
  txn_t exp_q[$];
  txn_t last_log[$];
  int lat = 0;
  int fixed_lat = -1;
  int wait_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ready = 1'b0;
      wait_n = 0;
    end else if (bus.mem_req) begin
      if (wait_n >= lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[15:1]];
      end else begin
        bus.mem_ready = 1'b0;
        wait_n++;
      end
    end else begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ready) begin
      log_q.push_back('{bus.mem_addr, bus.mem_wr, bus.mem_wr ? bus.mem_wdata : bus.mem_rdata});
      if (bus.mem_wr) mem[bus.mem_addr[15:1]] = bus.mem_wdata;
      wait_n = 0;
      lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
  end

  // Behavioural cache model.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [9:0]  m_tag   [8];
  logic [15:0] m_data  [8][4];

  logic        exp_err, exp_dd, exp_first_stall;
  logic [15:0] exp_rdata;

  task automatic model_reset();
    for (int l = 0; l < 8; l++) begin
      m_valid[l] = 0;
      m_dirty[l] = 0;
    end
  endtask

  task automatic model_writeback(input int l);
    logic [15:0] ad;
    for (int k = 0; k < 4; k++) begin
      ad = {m_tag[l], 3'(l), 2'(k), 1'b0};
      exp_q.push_back('{ad, 1'b1, m_data[l][k]});
      rmem[ad[15:1]] = m_data[l][k];
    end
    m_dirty[l] = 0;
  endtask

  task automatic model_access(input logic en, input logic wr, input logic dump,
                              input logic [15:0] a, input logic [15:0] wd);
    int l;
    int w;
    logic [9:0] t;
    logic [15:0] ad;
    exp_q.delete();
    exp_err = 0; exp_dd = 0; exp_first_stall = 0; exp_rdata = 16'h0;
    l = int'(a[5:3]);
    w = int'(a[2:1]);
    t = a[15:6];
    if (dump) begin
      exp_first_stall = 1;
      exp_dd = 1;
      for (int i = 0; i < 8; i++) if (m_valid[i] && m_dirty[i]) model_writeback(i);
    end else if (en && a[0]) begin
      exp_err = 1;
    end else if (en) begin
      if (!(m_valid[l] && m_tag[l] == t)) begin
        exp_first_stall = 1;
        if (m_valid[l] && m_dirty[l]) model_writeback(l);
        for (int k = 0; k < 4; k++) begin
          ad = {t, 3'(l), 2'(k), 1'b0};
          m_data[l][k] = rmem[ad[15:1]];
          exp_q.push_back('{ad, 1'b0, rmem[ad[15:1]]});
        end
        m_valid[l] = 1;
        m_tag[l] = t;
        m_dirty[l] = 0;
      end
      if (wr) begin
        m_data[l][w] = wd;
        m_dirty[l] = 1;
      end else begin
        exp_rdata = m_data[l][w];
      end
    end
  endtask

  // Compare process.
  bit in_acc = 0;
  bit quiet = 0;
  int acc_cyc = 0;
  int dd_count = 0;
  logic [15:0] last_rdata;
  logic        last_err;
  bit          hold_pend = 0;
  logic [33:0] hold_vec;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", {Stall, Err, DumpDone, bus.mem_req, bus.mem_wr, bus.mem_addr,
                          bus.mem_wdata, MemReadData}, 64'h0);
      hold_pend = 0;
    end else begin
      if (DumpDone) dd_count++;
      if (!bus.mem_req) chk("bus_idle", {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 64'h0);
      if (hold_pend)
        chk("req_hold", {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, hold_vec);
      hold_pend = bus.mem_req && !bus.mem_ready;
      hold_vec = {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
      if (in_acc) begin
        if (acc_cyc == 0) chk("first_stall", Stall, exp_first_stall);
        if (!Stall) begin
          chk("err", Err, exp_err);
          chk("rdata", MemReadData, exp_rdata);
          chk("dumpdone", DumpDone, exp_dd);
          chk("txn_count", 64'(log_q.size()), 64'(exp_q.size()));
          for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("txn%0d", i), {log_q[i].addr, log_q[i].wr, log_q[i].data},
                {exp_q[i].addr, exp_q[i].wr, exp_q[i].data});
          last_rdata = MemReadData;
          last_err = Err;
          last_log = log_q;
          log_q.delete();
        end else begin
          chk("stall_flags", {Err, DumpDone}, 64'h0);
        end
        acc_cyc++;
      end else if (!quiet) begin
        chk("idle_outputs", {Stall, Err, DumpDone, bus.mem_req, MemReadData}, 64'h0);
      end
    end
  end

  task automatic access(input logic en, input logic wr, input logic dump,
                        input logic [15:0] a, input logic [15:0] wd);
    bit done = 0;
    model_access(en, wr, dump, a, wd);
    ALUOut_tomem = a;
    ReadData2_tomem = wd;
    DMemEn_tomem = en;
    DMemWrite_tomem = wr;
    DMemDump_tomem = dump;
    acc_cyc = 0;
    in_acc = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (!Stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL access_timeout: got Stall=1 for 400 cycles expected completion, addr %0h", a);
    end
    @(posedge clk);
    #1;
    in_acc = 0;
    DMemEn_tomem = 0;
    DMemWrite_tomem = 0;
    DMemDump_tomem = 0;
  endtask

  task automatic do_reset();
    in_acc = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    model_reset();
    log_q.delete();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] tags [4];
  int dd_before;

  initial begin
    logic [15:0] a;
    logic [15:0] v;
    int r;
    int mism;
    bit seen;
    tags[0] = 10'h000; tags[1] = 10'h001; tags[2] = 10'h021; tags[3] = 10'h3FF;
    for (int i = 0; i < 32768; i++) begin
      v = 16'(i * 32'h9E37 + 32'h1357);
      mem[i] = v;
      rmem[i] = v;
    end
    mem[16'h0046 >> 1] = 16'hBEEF;
    rmem[16'h0046 >> 1] = 16'hBEEF;
    mem[16'h0102 >> 1] = 16'hC0DE;
    rmem[16'h0102 >> 1] = 16'hC0DE;

    do_reset();

    // Cold load, two-cycle memory latency.
    fixed_lat = 2;
    lat = 2;
    access(1, 0, 0, 16'h0046, 16'h0);
    chk("cold_rdata", last_rdata, 16'hBEEF);
    chk("cold_nfill", 64'(last_log.size()), 4);
    if (last_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("cold_fill_addr", last_log[i].addr, 16'h0040 + 16'(2 * i));

    // Unaligned access.
    access(1, 0, 0, 16'h0043, 16'h0);
    chk("unaligned_err", last_err, 1'b1);
    chk("unaligned_nreq", 64'(last_log.size()), 0);

    // Back-to-back hits on the resident line.
    for (int i = 0; i < 4; i++) begin
      access(1, 0, 0, 16'h0040 + 16'(2 * i), 16'h0);
      chk("b2b_nreq", 64'(last_log.size()), 0);
    end

    // Store hit then conflicting load.
    access(1, 1, 0, 16'h0046, 16'h1234);
    access(1, 0, 0, 16'h0846, 16'h0);
    chk("conflict_ntxn", 64'(last_log.size()), 8);
    if (last_log.size() == 8) begin
      chk("conflict_wb", {last_log[3].addr, last_log[3].wr, last_log[3].data},
          {16'h0046, 1'b1, 16'h1234});
      chk("conflict_fill", {last_log[4].addr, last_log[4].wr}, {16'h0840, 1'b0});
    end
    chk("conflict_mem", mem[16'h0046 >> 1], 16'h1234);

    // Flush with dirty lines 2 and 5.
    do_reset();
    fixed_lat = -1;
    access(1, 1, 0, 16'h0010, 16'h1111);
    access(1, 1, 0, 16'h0028, 16'h2222);
    access(1, 0, 0, 16'h0000, 16'h0);
    dd_before = dd_count;
    access(0, 0, 1, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("flush_pulses", 64'(dd_count - dd_before), 1);
    chk("flush_ntxn", 64'(last_log.size()), 8);
    if (last_log.size() == 8) begin
      chk("flush_first", {last_log[0].addr, last_log[0].wr, last_log[0].data},
          {16'h0010, 1'b1, 16'h1111});
      chk("flush_second", {last_log[4].addr, last_log[4].wr, last_log[4].data},
          {16'h0028, 1'b1, 16'h2222});
    end
    access(0, 0, 1, 16'h0, 16'h0);
    chk("reflush_ntxn", 64'(last_log.size()), 0);
    access(1, 0, 0, 16'h0010, 16'h0);
    chk("post_flush_hit", {16'(last_log.size()), last_rdata}, {16'h0, 16'h1111});

    // Reset in the middle of a fill.
    do_reset();
    fixed_lat = 1;
    quiet = 1;
    ALUOut_tomem = 16'h0102;
    DMemEn_tomem = 1;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (log_q.size() >= 2) begin
        seen = 1;
        break;
      end
    end
    chk("midfill_reached", seen, 1'b1);
    rst = 1;
    #1;
    chk("midfill_rst_bus", {bus.mem_req, Stall}, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    DMemEn_tomem = 0;
    quiet = 0;
    model_reset();
    log_q.delete();
    @(posedge clk);
    #1;
    access(1, 0, 0, 16'h0102, 16'h0);
    chk("refetch", {16'(last_log.size()), last_rdata}, {16'h4, 16'hC0DE});

    // Randomized mix over a few conflicting tags.
    fixed_lat = -1;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0};
      if (r < 3) access(0, 0, 1, a, 16'h0);
      else if (r < 10) access(1, 1'($urandom_range(0, 1)), 0, a | 16'h1, 16'($urandom));
      else if (r < 18) access(0, 1'($urandom_range(0, 1)), 0, a, 16'($urandom));
      else access(1, 1'($urandom_range(0, 1)), 0, a, 16'($urandom));
    end
    access(0, 0, 1, 16'h0, 16'h0);
    mism = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== rmem[i]) mism++;
    chk("mem_image", 64'(mism), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
